// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath/control field widths, NOP control
// encoding and the inter-stage register occupancy state encoding.
package mips_pkg;

  localparam int DATA_W    = 32;
  localparam int MUXCTRL_W = 16;
  localparam int MEMCTRL_W = 3;
  localparam int ALUCTRL_W = 5;
  localparam int CTRL_W    = MUXCTRL_W + MEMCTRL_W + ALUCTRL_W;
  localparam int RD_W      = 5;

  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_HALF  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef struct packed {
    logic [MUXCTRL_W-1:0] muxctrl;
    logic [MEMCTRL_W-1:0] memctrl;
    logic [ALUCTRL_W-1:0] aluctrl;
  } ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; sticks at all-ones and clears only on reset.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage.sv
// Inter-stage pipeline register with valid/ready handshake, optional skid entry,
// flush/bubble control and saturating stall/bubble debug counters.
module pipe_stage #(
  parameter int                DATA_W   = 64,
  parameter int                CTRL_W   = 24,
  parameter int                RD_W     = 5,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
  parameter int                SKID_EN  = 1,
  parameter int                CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              bubble,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [RD_W-1:0]   out_rd,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);
  import mips_pkg::*;

  // Handshake: a transfer happens on any edge where valid and ready are both
  // high; valid never depends on ready, and an offered entry must stay stable
  // until taken.
  logic [1:0]        state, state_d;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [RD_W-1:0]   main_rd, skid_rd;
  logic              main_valid, skid_valid, ready_q;
  logic              accept, out_fire;
  logic              load_main_in, load_main_skid, load_skid;

  assign main_valid = (state != ST_EMPTY);
  assign skid_valid = (state == ST_FULL);

  // With the skid entry, ready is a flop (only the hazard gate is combinational).
  assign in_ready = (SKID_EN != 0) ? (ready_q & ~bubble)
                                   : ((~main_valid | out_ready) & ~bubble);
  assign accept   = in_valid & in_ready & ~flush;
  assign out_fire = main_valid & out_ready;

  always_comb begin
    state_d        = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_d      = ST_HALF;
          load_main_in = 1'b1;
        end
      end
      ST_HALF: begin
        if (accept && out_fire) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_d        = ST_HALF;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d        = ST_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= ST_EMPTY;
      ready_q   <= 1'b1;
      main_data <= '0;
      main_ctrl <= '0;
      main_rd   <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
      skid_rd   <= '0;
    end else begin
      state   <= state_d;
      ready_q <= (state_d != ST_FULL);
      if (load_main_in) begin
        main_data <= in_data;
        main_ctrl <= in_ctrl;
        main_rd   <= in_rd;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
        main_rd   <= skid_rd;
      end
      if (load_skid) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
        skid_rd   <= in_rd;
      end else if (load_main_skid) begin
        skid_data <= '0;
        skid_ctrl <= '0;
        skid_rd   <= '0;
      end
    end
  end

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_valid ? main_ctrl : CTRL_NOP;
  assign out_rd    = main_valid ? main_rd : '0;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (main_valid & ~out_ready),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (bubble & in_valid),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage.sv
// Directed bench for pipe_stage: skid (default), small-counter and no-skid
// instances share one stimulus stream; each test checks the relevant instance.
module tb_pipe_stage;

  localparam int DW = 64;
  localparam int CW = 24;
  localparam int RW = 5;

  logic          clock, reset;
  logic          in_valid, bubble, flush, out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic [RW-1:0] in_rd;

  logic          a_in_ready, a_out_valid, s_in_ready, s_out_valid, n_in_ready, n_out_valid;
  logic [DW-1:0] a_out_data, s_out_data, n_out_data;
  logic [CW-1:0] a_out_ctrl, s_out_ctrl, n_out_ctrl;
  logic [RW-1:0] a_out_rd, s_out_rd, n_out_rd;
  logic [1:0]    a_occ, s_occ, n_occ;
  logic [15:0]   a_stall, a_bub;
  logic [3:0]    s_stall, s_bub, n_stall, n_bub;

  int checks = 0;
  int errors = 0;

  pipe_stage dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_rd(in_rd), .bubble(bubble), .flush(flush),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_ctrl(a_out_ctrl), .out_rd(a_out_rd), .occupancy(a_occ),
    .stall_cnt(a_stall), .bubble_cnt(a_bub)
  );

  pipe_stage #(.CNT_W(4)) dut_sat (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_rd(in_rd), .bubble(bubble), .flush(flush),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_ctrl(s_out_ctrl), .out_rd(s_out_rd), .occupancy(s_occ),
    .stall_cnt(s_stall), .bubble_cnt(s_bub)
  );

  pipe_stage #(.SKID_EN(0), .CNT_W(4)) dut_ns (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_rd(in_rd), .bubble(bubble), .flush(flush),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data),
    .out_ctrl(n_out_ctrl), .out_rd(n_out_rd), .occupancy(n_occ),
    .stall_cnt(n_stall), .bubble_cnt(n_bub)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- entry encoding ----------------
  // Entry tag k carries data=k, ctrl=0x0A0000|k, rd=k; tag 0 means "no entry".
  function automatic logic [DW-1:0] data_of(int k);
    return DW'(k);
  endfunction
  function automatic logic [CW-1:0] ctrl_of(int k);
    return 24'h0A0000 | CW'(k);
  endfunction
  function automatic logic [RW-1:0] rd_of(int k);
    return RW'(k);
  endfunction

  typedef struct {
    int         in_tag;
    logic       bub;
    logic       fl;
    logic       ordy;
    int         out_tag;
    logic       exp_ready;
    logic [1:0] exp_occ;
  } vec_t;

  function automatic vec_t mk(int it, logic b, logic f, logic o, int ot, logic ir, logic [1:0] oc);
    vec_t v;
    v.in_tag = it; v.bub = b; v.fl = f; v.ordy = o;
    v.out_tag = ot; v.exp_ready = ir; v.exp_occ = oc;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(int tag, logic b, logic f, logic o);
    in_valid  = (tag != 0);
    in_data   = (tag != 0) ? data_of(tag) : '0;
    in_ctrl   = (tag != 0) ? ctrl_of(tag) : '0;
    in_rd     = (tag != 0) ? rd_of(tag) : '0;
    bubble    = b;
    flush     = f;
    out_ready = o;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(vec_t v, int idx, bit ns);
    logic          ov, ir;
    logic [DW-1:0] od;
    logic [CW-1:0] oc;
    logic [RW-1:0] orr;
    logic [1:0]    occ;
    @(negedge clock);
    drive(v.in_tag, v.bub, v.fl, v.ordy);
    #2;
    if (ns) begin
      ov = n_out_valid; ir = n_in_ready; od = n_out_data; oc = n_out_ctrl; orr = n_out_rd; occ = n_occ;
    end else begin
      ov = a_out_valid; ir = a_in_ready; od = a_out_data; oc = a_out_ctrl; orr = a_out_rd; occ = a_occ;
    end
    chk($sformatf("%s[%0d] out_valid", ns ? "ns" : "sk", idx), 64'(ov), 64'(v.out_tag != 0));
    chk($sformatf("%s[%0d] out_ctrl", ns ? "ns" : "sk", idx), 64'(oc),
        (v.out_tag != 0) ? 64'(ctrl_of(v.out_tag)) : 64'(0));
    chk($sformatf("%s[%0d] out_rd", ns ? "ns" : "sk", idx), 64'(orr),
        (v.out_tag != 0) ? 64'(rd_of(v.out_tag)) : 64'(0));
    chk($sformatf("%s[%0d] in_ready", ns ? "ns" : "sk", idx), 64'(ir), 64'(v.exp_ready));
    chk($sformatf("%s[%0d] occupancy", ns ? "ns" : "sk", idx), 64'(occ), 64'(v.exp_occ));
    if (v.out_tag != 0)
      chk($sformatf("%s[%0d] out_data", ns ? "ns" : "sk", idx), od, data_of(v.out_tag));
  endtask

  // The no-skid stage must never hold more than one entry.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      checks++;
      if (n_occ > 2'd1) begin
        errors++;
        $display("FAIL ns_occupancy_bound: got %0d expected <=1", n_occ);
      end
    end
  end

  vec_t vm[19];
  vec_t vn[7];

  initial begin
    // tags: 1=A 2=B 3=C 4=X 5=A2 6=B2 7=D 8=F 9=G
    vm[0]  = mk(1, 0, 0, 0, 0, 1, 0);
    vm[1]  = mk(2, 0, 0, 0, 1, 1, 1);
    vm[2]  = mk(3, 0, 0, 0, 1, 0, 2);
    vm[3]  = mk(3, 0, 0, 1, 1, 0, 2);
    vm[4]  = mk(3, 0, 0, 1, 2, 1, 1);
    vm[5]  = mk(0, 0, 0, 1, 3, 1, 1);
    vm[6]  = mk(0, 0, 0, 1, 0, 1, 0);
    vm[7]  = mk(4, 1, 0, 1, 0, 0, 0);
    vm[8]  = mk(4, 1, 0, 1, 0, 0, 0);
    vm[9]  = mk(4, 0, 0, 1, 0, 1, 0);
    vm[10] = mk(0, 0, 0, 1, 4, 1, 1);
    vm[11] = mk(0, 0, 0, 1, 0, 1, 0);
    vm[12] = mk(5, 0, 0, 0, 0, 1, 0);
    vm[13] = mk(6, 0, 0, 0, 5, 1, 1);
    vm[14] = mk(7, 0, 1, 0, 5, 0, 2);
    vm[15] = mk(0, 0, 0, 1, 0, 1, 0);
    vm[16] = mk(8, 0, 0, 0, 0, 1, 0);
    vm[17] = mk(9, 1, 1, 0, 8, 0, 1);
    vm[18] = mk(0, 0, 0, 1, 0, 1, 0);

    vn[0] = mk(1, 0, 0, 0, 0, 1, 0);
    vn[1] = mk(2, 0, 0, 0, 1, 0, 1);
    vn[2] = mk(2, 0, 0, 1, 1, 1, 1);
    vn[3] = mk(3, 0, 0, 0, 2, 0, 1);
    vn[4] = mk(3, 0, 0, 1, 2, 1, 1);
    vn[5] = mk(0, 0, 0, 1, 3, 1, 1);
    vn[6] = mk(0, 0, 0, 1, 0, 1, 0);

    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0);

    // Reset state.
    do_reset();
    #2;
    chk("rst out_valid", 64'(a_out_valid), 64'(0));
    chk("rst out_ctrl", 64'(a_out_ctrl), 64'(0));
    chk("rst out_data", a_out_data, 64'(0));
    chk("rst out_rd", 64'(a_out_rd), 64'(0));
    chk("rst occupancy", 64'(a_occ), 64'(0));
    chk("rst in_ready", 64'(a_in_ready), 64'(1));

    // Reset mid-operation with flush/bubble/valid also asserted.
    apply(vm[0], 0, 1'b0);
    apply(vm[1], 1, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    drive(3, 1'b1, 1'b1, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("midrst occupancy", 64'(a_occ), 64'(0));
    chk("midrst out_valid", 64'(a_out_valid), 64'(0));
    chk("midrst out_ctrl", 64'(a_out_ctrl), 64'(0));
    chk("midrst out_data", a_out_data, 64'(0));
    chk("midrst in_ready", 64'(a_in_ready), 64'(1));
    chk("midrst stall_cnt", 64'(a_stall), 64'(0));
    chk("midrst bubble_cnt", 64'(a_bub), 64'(0));

    // Backpressure/skid, bubble and flush sequences on the skid stage.
    for (int i = 0; i < 19; i++) begin
      apply(vm[i], i, 1'b0);
      if (i == 11) begin
        chk("skid stall_cnt", 64'(a_stall), 64'(2));
        chk("bubble bubble_cnt", 64'(a_bub), 64'(2));
      end
    end
    chk("end stall_cnt", 64'(a_stall), 64'(5));
    chk("end bubble_cnt", 64'(a_bub), 64'(3));

    // Streaming 1..8 with out_ready held high.
    for (int i = 1; i <= 9; i++) begin
      @(negedge clock);
      drive((i <= 8) ? i : 0, 1'b0, 1'b0, 1'b1);
      #2;
      chk($sformatf("stream[%0d] in_ready", i), 64'(a_in_ready), 64'(1));
      chk($sformatf("stream[%0d] occupancy", i), 64'(a_occ), (i == 1) ? 64'(0) : 64'(1));
      if (i >= 2) begin
        chk($sformatf("stream[%0d] out_valid", i), 64'(a_out_valid), 64'(1));
        chk($sformatf("stream[%0d] out_data", i), a_out_data, 64'(i - 1));
      end
    end
    @(negedge clock);
    drive(0, 1'b0, 1'b0, 1'b1);
    #2;
    chk("stream drained out_valid", 64'(a_out_valid), 64'(0));

    // Counter saturation: one entry stalled for 20 cycles.
    do_reset();
    @(negedge clock);
    drive(1, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    drive(0, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge clock);
    #2;
    chk("sat main stall_cnt", 64'(a_stall), 64'(20));
    chk("sat cnt4 stall_cnt", 64'(s_stall), 64'(15));
    chk("sat noskid stall_cnt", 64'(n_stall), 64'(15));

    // No-skid stage: combinational ready follows out_ready.
    do_reset();
    for (int i = 0; i < 7; i++) apply(vn[i], i, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
Name: pipe_stage

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline register used between IF/ID/EX/MEM/WB.
- Carries a data payload, a control word and a destination-register field under a valid/ready handshake.
- Optional skid buffer; built-in flush for taken branches/jumps and bubble insertion for load-use hazards.
- Saturating stall and bubble counters, exported for the debug UI (hex/LCD).

Parameters:
- DATA_W, 64, payload width (e.g. two 32-bit operands).
- CTRL_W, 24, control word width (muxctrl+memctrl+aluctrl).
- RD_W, 5, destination register field width.
- CTRL_NOP, 0, control value presented whenever out_valid=0.
- SKID_EN, 1, 1 = two-entry skid buffer (registered in_ready); 0 = single register (combinational in_ready).
- CNT_W, 16, debug counter width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept this cycle
- in_data  in  DATA_W  payload
- in_ctrl  in  CTRL_W  control word
- in_rd  in  RD_W  destination register
- bubble  in  1  hazard unit: hold upstream, emit NOP downstream
- flush  in  1  discard all held and incoming entries
- out_valid  out  1  entry presented downstream
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  payload
- out_ctrl  out  CTRL_W  control word; CTRL_NOP when out_valid=0
- out_rd  out  RD_W  destination; 0 when out_valid=0
- occupancy  out  2  entries held (0..2)
- stall_cnt  out  CNT_W  cycles with out_valid & ~out_ready, saturating
- bubble_cnt  out  CNT_W  cycles with bubble & in_valid, saturating

Behaviour:
- Reset (reset=0 at a clock edge):
  - state EMPTY; main/skid valid, data, ctrl and rd cleared; counters 0.
  - Outputs after reset: out_valid=0, out_ctrl=CTRL_NOP, out_data=0, out_rd=0, occupancy=0, in_ready=1.
  - Reset overrides flush, bubble and any handshake in the same cycle.
- Definitions:
  - accept = in_valid & in_ready & ~bubble & ~flush.
  - out_fire = out_valid & out_ready.
- Latency: one cycle from accept to out_valid. Ordering is strictly FIFO.
- SKID_EN=1 state machine (EMPTY / HALF / FULL):
  - in_ready = ~skid_valid & ~bubble. in_ready is registered except for the bubble gate.
  - EMPTY: accept -> HALF (main<=in).
  - HALF:
    - accept & out_fire -> HALF (main<=in).
    - accept & ~out_fire -> FULL (skid<=in).
    - ~accept & out_fire -> EMPTY.
    - otherwise hold.
  - FULL: out_fire -> HALF (main<=skid, skid cleared); otherwise hold. No accept is possible in FULL.
- SKID_EN=0:
  - Single main register.
  - in_ready = (~main_valid | out_ready) & ~bubble (combinational).
  - occupancy never exceeds 1.
- Bubble:
  - in_ready is forced to 0, so the upstream entry is held.
  - Held entries still drain on out_fire. Once drained, the stage presents valid=0 / CTRL_NOP, i.e. it inserts a NOP downstream.
- Flush:
  - At the next edge, state -> EMPTY and all valid bits are cleared.
  - Any input offered in the same cycle is discarded.
  - out_fire in the flush cycle still counts as delivered downstream.
  - Flush has priority over bubble.
- Output gating: out_ctrl=CTRL_NOP and out_rd=0 whenever out_valid=0, whatever the stale register contents.
- Counters:
  - Increment by 1 per qualifying cycle and stick at 2^CNT_W-1.
  - Not cleared by flush; cleared only by reset.
- occupancy = main_valid + skid_valid.

Decomposition:
- Shared package mips_pkg:
  - width constants DATA_W=32, CTRL field widths (MUXCTRL_W=16, MEMCTRL_W=3, ALUCTRL_W=5).
  - CTRL_NOP encoding.
  - state encoding EMPTY=2'd0, HALF=2'd1, FULL=2'd2.
- One natural sub-module: sat_counter (parameter CNT_W; ports clock, reset, inc, count), instantiated twice.

Test Plan:
- Reset mid-operation:
  - Stimulus: load 2 entries, then hold reset=0 for 1 cycle.
  - Required: occupancy=0, out_valid=0, out_ctrl=CTRL_NOP, in_ready=1, stall_cnt=0, bubble_cnt=0.
- Streaming (SKID_EN=1):
  - Stimulus: out_ready=1; feed data 1..8 back-to-back.
  - Required: out_data 1..8 in order starting 1 cycle after first accept; no gaps; in_ready stays 1; occupancy=1.
- Backpressure/skid:
  - Stimulus: out_ready=0 while feeding A, B, C.
  - Required: A in main, B in skid, in_ready=0 after B, C held upstream.
  - Then out_ready=1: outputs A, B, C on consecutive cycles; stall_cnt equals the number of out_ready=0 cycles with out_valid=1.
- Bubble:
  - Stimulus: in_valid=1 with data X, bubble=1 for 2 cycles, out_ready=1.
  - Required: in_ready=0 for those cycles; 2 cycles of out_valid=0 / out_ctrl=CTRL_NOP; X emitted after bubble drops; bubble_cnt=2.
- Flush:
  - Stimulus: FULL with A, B; assert flush together with in_valid=1 (data D).
  - Required: next cycle occupancy=0, out_valid=0, and D is never emitted.
  - Also flush+bubble in the same cycle -> EMPTY, in_ready=0 that cycle.
- Saturation / SKID_EN=0:
  - Stimulus: CNT_W=4; stall for 20 cycles.
  - Required: stall_cnt sticks at 15.
  - With SKID_EN=0: in_ready follows out_ready in the same cycle when main is full, and occupancy is never above 1.
